// File: rtl/data_mem_responder.sv
// Word-addressed data memory with a wait-state FSM, byte-enable writes and a
// single memory-mapped output register, behind a valid/ready request/response pair.
module data_mem_responder #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] GPIO_ADDR   = 32'hFFFF_FFF0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] gpio_out
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        lat_we;
  logic [31:0] lat_addr, lat_wdata;
  logic [3:0]  lat_be;
  logic [31:0] mem [DEPTH];

  logic        accept, go, acc_we;
  logic [31:0] acc_addr, acc_wdata, be_mask, gpio_next;
  logic [3:0]  acc_be;
  logic        misalign, hit_gpio, hit_mem;
  logic [AW-1:0] idx;

  assign accept = req_valid && req_ready;
  // With zero wait states the access happens on the accepting edge itself,
  // so the decode must look at the live request rather than the latched copy.
  assign go = (state == IDLE) ? (accept && WAIT_CYCLES == 0)
                              : (state == WAIT && cnt == 4'd0);

  assign acc_we    = (state == IDLE) ? req_we    : lat_we;
  assign acc_addr  = (state == IDLE) ? req_addr  : lat_addr;
  assign acc_wdata = (state == IDLE) ? req_wdata : lat_wdata;
  assign acc_be    = (state == IDLE) ? req_be    : lat_be;

  assign misalign = |acc_addr[1:0];
  assign hit_gpio = !misalign && (acc_addr == GPIO_ADDR);
  assign hit_mem  = !misalign && !hit_gpio && ({2'b00, acc_addr[31:2]} < 32'(DEPTH));
  assign idx      = acc_addr[AW+1:2];

  always_comb begin
    be_mask = '0;
    for (int b = 0; b < 4; b++) be_mask[8*b +: 8] = {8{acc_be[b]}};
  end

  assign gpio_next = (gpio_out & ~be_mask) | (acc_wdata & be_mask);

  // Array is deliberately not reset; reset gating keeps an aborted request from writing.
  always_ff @(posedge clk) begin
    if (go && reset && hit_mem && acc_we) begin
      for (int b = 0; b < 4; b++)
        if (acc_be[b]) mem[idx][8*b +: 8] <= acc_wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      gpio_out   <= '0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_be     <= '0;
    end else begin
      if (accept) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_be    <= req_be;
      end
      if (go) begin
        state      <= RESP;
        req_ready  <= 1'b0;
        resp_valid <= 1'b1;
        resp_err   <= !(hit_gpio || hit_mem);
        resp_rdata <= '0;
        if (hit_gpio) begin
          if (acc_we) gpio_out   <= gpio_next;
          else        resp_rdata <= gpio_out;
        end else if (hit_mem && !acc_we) begin
          resp_rdata <= mem[idx];
        end
      end else begin
        case (state)
          IDLE: begin
            req_ready <= !accept;
            if (accept) begin
              state <= WAIT;
              cnt   <= 4'(WAIT_CYCLES - 1);
            end
          end
          WAIT: cnt <= cnt - 4'd1;
          RESP: begin
            if (resp_ready) begin
              state      <= IDLE;
              resp_valid <= 1'b0;
              req_ready  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: stimulus pushes expected responses, a monitor pops them on
// every response handshake of the WAIT_CYCLES=1 instance; a second instance covers reset abort.
module tb_data_mem_responder;
  localparam logic [31:0] GPIO = 32'hFFFF_FFF0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
  logic [31:0] req_addr, req_wdata, resp_rdata, gpio_out;
  logic [3:0]  req_be;
  logic        reset3, req_valid3, req_ready3, resp_valid3, resp_err3;
  logic [31:0] resp_rdata3, gpio_out3;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(1), .GPIO_ADDR(GPIO)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .gpio_out(gpio_out)
  );

  data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(3), .GPIO_ADDR(GPIO)) u_dut3 (
    .clk(clk), .reset(reset3), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid3), .resp_ready(resp_ready), .resp_rdata(resp_rdata3),
    .resp_err(resp_err3), .gpio_out(gpio_out3)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset && resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got %h expected no response", resp_rdata);
      end else begin
        e = sb.pop_front();
        check({e.name, "_rdata"}, resp_rdata, e.rdata);
        check({e.name, "_err"}, 32'(resp_err), 32'(e.err));
      end
    end
  end

  // Presents a request, waits for acceptance, then scrambles the inputs.
  task automatic issue(string name, logic we, logic [31:0] addr, logic [31:0] wdata,
                       logic [3:0] be, logic [31:0] er, logic ee);
    int n;
    sb.push_back('{er, ee, name});
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL %s_accept: got req_ready 0 expected 1 within 50 cycles", name);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = ~we; req_addr = 32'h0000_0003;
    req_wdata = 32'h0BAD_F00D; req_be = ~be;
  endtask

  // Counts edges including the accepting one until resp_valid, then handshakes.
  task automatic wait_resp(string name, int exp_lat, bit gchk, logic [31:0] gexp);
    int n = 1;
    while (!resp_valid && n < 40) begin @(posedge clk); #1; n++; end
    check({name, "_latency"}, 32'(n), 32'(exp_lat));
    if (gchk) check({name, "_gpio"}, gpio_out, gexp);
    if (resp_ready) begin
      @(posedge clk); #1;
      check({name, "_valid_drop"}, 32'(resp_valid), 32'd0);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0; reset3 = 1'b0; req_valid = 1'b0; req_valid3 = 1'b0;
    req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0; resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_gpio", gpio_out, 32'd0);
    reset = 1'b1; #1;
    check("rel_ready_before_edge", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    check("rel_ready_after_edge", 32'(req_ready), 32'd1);

    issue("wr10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0); wait_resp("wr10", 2, 0, 0);
    issue("rd10", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);  wait_resp("rd10", 2, 0, 0);
    issue("wr20", 1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0); wait_resp("wr20", 2, 0, 0);
    issue("wr20be", 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0); wait_resp("wr20be", 2, 0, 0);
    issue("rd20", 1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);  wait_resp("rd20", 2, 0, 0);
    issue("wr0", 1'b1, 32'h0, 32'h12345678, 4'hF, 32'h0, 1'b0);   wait_resp("wr0", 2, 0, 0);
    issue("rd22", 1'b0, 32'h22, 32'h0, 4'h0, 32'h0, 1'b1);         wait_resp("rd22", 2, 0, 0);
    issue("wr400", 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1); wait_resp("wr400", 2, 0, 0);
    issue("wr0_nobe", 1'b1, 32'h0, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0); wait_resp("wr0_nobe", 2, 0, 0);
    issue("rd0", 1'b0, 32'h0, 32'h0, 4'h0, 32'h12345678, 1'b0);    wait_resp("rd0", 2, 0, 0);
    issue("wr3fc", 1'b1, 32'h3FC, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0); wait_resp("wr3fc", 2, 0, 0);
    issue("rd3fc", 1'b0, 32'h3FC, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0); wait_resp("rd3fc", 2, 0, 0);

    check("gpio_pre", gpio_out, 32'd0);
    issue("wr_gpio", 1'b1, GPIO, 32'h000000A5, 4'hF, 32'h0, 1'b0); wait_resp("wr_gpio", 2, 1, 32'hA5);
    issue("rd_gpio", 1'b0, GPIO, 32'h0, 4'h0, 32'h000000A5, 1'b0);  wait_resp("rd_gpio", 2, 0, 0);

    // Backpressure with a competing request held on the bus.
    resp_ready = 1'b0;
    issue("bp_rd", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
    wait_resp("bp_rd", 2, 0, 0);
    sb.push_back('{32'h11BB33DD, 1'b0, "bp_next"});
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h20; req_be = 4'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(resp_valid), 32'd1);
      check("bp_rdata", resp_rdata, 32'hDEADBEEF);
      check("bp_err", 32'(resp_err), 32'd0);
      check("bp_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 32'(resp_valid), 32'd0);
    check("bp_release_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    check("bp_next_accepted", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    wait_resp("bp_next", 2, 0, 0);

    // Reset abort on the three-wait-state instance.
    reset3 = 1'b1;
    @(posedge clk); #1;
    req_valid3 = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h1234; req_be = 4'hF;
    @(negedge clk);
    check("d3_ready", 32'(req_ready3), 32'd1);
    @(posedge clk); #1;
    req_valid3 = 1'b0; req_wdata = 32'h0BAD_F00D;
    n = 1;
    while (!resp_valid3 && n < 40) begin @(posedge clk); #1; n++; end
    check("d3_wr_latency", 32'(n), 32'd4);
    check("d3_wr_err", 32'(resp_err3), 32'd0);
    @(posedge clk); #1;
    req_valid3 = 1'b1; req_wdata = 32'h55;
    @(negedge clk);
    @(posedge clk); #1;
    req_valid3 = 1'b0;
    @(posedge clk); #1;
    reset3 = 1'b0;
    #1;
    check("d3_rst_ready", 32'(req_ready3), 32'd0);
    check("d3_rst_gpio", gpio_out3, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("d3_rst_valid", 32'(resp_valid3), 32'd0);
    end
    reset3 = 1'b1;
    @(posedge clk); #1;
    req_valid3 = 1'b1; req_we = 1'b0; req_addr = 32'h40;
    @(negedge clk);
    @(posedge clk); #1;
    req_valid3 = 1'b0;
    n = 1;
    while (!resp_valid3 && n < 40) begin @(posedge clk); #1; n++; end
    check("d3_rd_latency", 32'(n), 32'd4);
    check("d3_rd_rdata", resp_rdata3, 32'h1234);
    check("d3_gpio_after", gpio_out3, 32'd0);
    @(posedge clk); #1;

    repeat (3) @(posedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
